// File: rtl/reg_file_ctrl_if.sv
// Bus bundle between the register-file command controller and its neighbours
// (UART RX deserialiser, register file, TX FIFO).
//
// Signals:
//   rx_p_data   received byte, valid when rx_d_vld is high
//   rx_d_vld    one-cycle strobe per received byte
//   rd_data     register-file read data
//   rd_data_vld register-file read-data valid
//   tx_full     TX FIFO full, no push while high
//   address     register-file address
//   wr_data     register-file write data
//   wr_en       one-cycle write strobe
//   rd_en       one-cycle read strobe
//   tx_p_data   byte pushed to the TX FIFO
//   tx_d_vld    one-cycle push strobe to the TX FIFO
//   cmd_err     one-cycle command error strobe
//   busy        high while a command is in progress
//
// Modports: master = the controller, slave = its environment.
interface reg_file_ctrl_if #(
    parameter int ADD_WIDTH  = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_vld;
    logic                  tx_full;
    logic [ADD_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  cmd_err;
    logic                  busy;

    modport master (
        input  rx_p_data, rx_d_vld, rd_data, rd_data_vld, tx_full,
        output address, wr_data, wr_en, rd_en, tx_p_data, tx_d_vld, cmd_err, busy
    );

    modport slave (
        output rx_p_data, rx_d_vld, rd_data, rd_data_vld, tx_full,
        input  address, wr_data, wr_en, rd_en, tx_p_data, tx_d_vld, cmd_err, busy
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// Command-side initiator for the register file. Parses UART RX frames
// (write: WR_CMD,addr,data / read: RD_CMD,addr) into register-file strobes
// and returns read data to the TX FIFO through a valid/full handshake.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  reg_file_ctrl_if.master (RX byte in, register-file access out,
//        read data in, TX push out, error and busy status out)
//
// Every output is registered: the output process computes next values and
// the register process loads them on the same edge as the state.
module reg_file_ctrl #(
    parameter int                         ADD_WIDTH  = 4,
    parameter int                         DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]      WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0]      RD_CMD     = 8'hBB,
    parameter int                         RD_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_ctrl_if.master bus
);

    localparam int                CNT_W       = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_TIMEOUT = CNT_W'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  timeout_s;
    logic                  addr_ok_s;
    logic                  is_cmd_s;

    logic [ADD_WIDTH-1:0]  address_r,   address_s;
    logic [DATA_WIDTH-1:0] wr_data_r,   wr_data_s;
    logic [DATA_WIDTH-1:0] tx_p_data_r, tx_p_data_s;
    logic                  wr_en_r,     wr_en_s;
    logic                  rd_en_r,     rd_en_s;
    logic                  tx_d_vld_r,  tx_d_vld_s;
    logic                  cmd_err_r,   cmd_err_s;
    logic                  busy_r;

    // Address bytes must fit the register file; the upper bits must be zero.
    assign addr_ok_s = ((bus.rx_p_data >> ADD_WIDTH) == {DATA_WIDTH{1'b0}});
    assign is_cmd_s  = (bus.rx_p_data == WR_CMD) || (bus.rx_p_data == RD_CMD);
    // The edge on which the counter would reach RD_TIMEOUT is the abort edge.
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign timeout_s = (cnt_inc_s == CNT_TIMEOUT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.rx_d_vld && (bus.rx_p_data == WR_CMD)) begin
                    state_nxt_s = WR_ADDR;
                end else if (bus.rx_d_vld && (bus.rx_p_data == RD_CMD)) begin
                    state_nxt_s = RD_ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (bus.rx_d_vld) begin
                    state_nxt_s = addr_ok_s ? WR_DATA : IDLE;
                end else begin
                    state_nxt_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (bus.rx_d_vld) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (bus.rx_d_vld) begin
                    state_nxt_s = addr_ok_s ? RD_WAIT : IDLE;
                end else begin
                    state_nxt_s = RD_ADDR;
                end
            end
            RD_WAIT: begin
                // Valid data beats a simultaneous timeout.
                if (bus.rd_data_vld) begin
                    state_nxt_s = TX_SEND;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            TX_SEND: begin
                if (!bus.tx_full) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TX_SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the RD_WAIT counter.
    always_comb begin
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        tx_d_vld_s  = 1'b0;
        cmd_err_s   = 1'b0;
        address_s   = address_r;
        wr_data_s   = wr_data_r;
        tx_p_data_s = tx_p_data_r;
        cnt_s       = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.rx_d_vld && !is_cmd_s) begin
                    cmd_err_s = 1'b1;
                end else begin
                    cmd_err_s = 1'b0;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (bus.rx_d_vld && addr_ok_s) begin
                    address_s = bus.rx_p_data[ADD_WIDTH-1:0];
                    rd_en_s   = (state_r == RD_ADDR);
                end else if (bus.rx_d_vld) begin
                    cmd_err_s = 1'b1;
                end else begin
                    cmd_err_s = 1'b0;
                end
            end
            WR_DATA: begin
                if (bus.rx_d_vld) begin
                    wr_data_s = bus.rx_p_data;
                    wr_en_s   = 1'b1;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            RD_WAIT: begin
                // Counter stays at zero on every exit from RD_WAIT.
                if (bus.rd_data_vld) begin
                    tx_p_data_s = bus.rd_data;
                end else if (timeout_s) begin
                    cmd_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            TX_SEND: begin
                tx_d_vld_s = !bus.tx_full;
            end
            default: begin
                cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            address_r   <= {ADD_WIDTH{1'b0}};
            wr_data_r   <= {DATA_WIDTH{1'b0}};
            tx_p_data_r <= {DATA_WIDTH{1'b0}};
            wr_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            tx_d_vld_r  <= 1'b0;
            cmd_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            address_r   <= address_s;
            wr_data_r   <= wr_data_s;
            tx_p_data_r <= tx_p_data_s;
            wr_en_r     <= wr_en_s;
            rd_en_r     <= rd_en_s;
            tx_d_vld_r  <= tx_d_vld_s;
            cmd_err_r   <= cmd_err_s;
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign bus.address   = address_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.tx_p_data = tx_p_data_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.tx_d_vld  = tx_d_vld_r;
    assign bus.cmd_err   = cmd_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: a hand-derived vector table, a few
// directed multi-cycle sequences, then randomized traffic against a
// transaction-level model built on a byte queue.
module tb_reg_file_ctrl;

    localparam int T = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    reg_file_ctrl_if #(.ADD_WIDTH(4), .DATA_WIDTH(8)) bus ();

    reg_file_ctrl #(
        .ADD_WIDTH(4), .DATA_WIDTH(8), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .RD_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rx_v;
        logic [7:0]  rx_b;
        logic        rd_v;
        logic [7:0]  rd_d;
        logic        tx_f;
        logic [24:0] exp;
    } vec_t;

    // Output vector: {wr_en, rd_en, tx_d_vld, cmd_err, busy, address, wr_data, tx_p_data}
    function automatic logic [24:0] ov(input logic wr, input logic rd, input logic txv,
                                       input logic err, input logic bsy, input logic [3:0] a,
                                       input logic [7:0] wd, input logic [7:0] txd);
        return {wr, rd, txv, err, bsy, a, wd, txd};
    endfunction

    function automatic logic [24:0] outv();
        return {bus.wr_en, bus.rd_en, bus.tx_d_vld, bus.cmd_err, bus.busy,
                bus.address, bus.wr_data, bus.tx_p_data};
    endfunction

    task automatic chk(input string name, input logic [24:0] got, input logic [24:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got wr=%b rd=%b txv=%b err=%b busy=%b a=%h wd=%h txd=%h, want wr=%b rd=%b txv=%b err=%b busy=%b a=%h wd=%h txd=%h",
                     name, got[24], got[23], got[22], got[21], got[20], got[19:16], got[15:8], got[7:0],
                     exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:16], exp[15:8], exp[7:0]);
        end
    endtask

    // Drive inputs for the next edge, clock, then settle past the edge.
    task automatic cyc(input logic rv, input logic [7:0] rb, input logic dv,
                       input logic [7:0] dd, input logic tf);
        bus.rx_d_vld    = rv;
        bus.rx_p_data   = rb;
        bus.rd_data_vld = dv;
        bus.rd_data     = dd;
        bus.tx_full     = tf;
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0] q[$];
    bit         m_read, m_tx;
    int         m_wait;
    logic [3:0] m_addr;
    logic [7:0] m_wd, m_txd;
    bit         m_wr, m_rd, m_txv, m_err;

    task automatic model_reset();
        q.delete();
        m_read = 0; m_tx = 0; m_wait = 0;
        m_addr = 4'h0; m_wd = 8'h00; m_txd = 8'h00;
        m_wr = 0; m_rd = 0; m_txv = 0; m_err = 0;
    endtask

    function automatic logic [24:0] mexp();
        return ov(m_wr, m_rd, m_txv, m_err, (m_read || m_tx || (q.size() != 0)),
                  m_addr, m_wd, m_txd);
    endfunction

    task automatic model_step(input logic rv, input logic [7:0] rb, input logic dv,
                              input logic [7:0] dd, input logic tf);
        logic [7:0] a;
        m_wr = 0; m_rd = 0; m_txv = 0; m_err = 0;
        if (m_tx) begin
            if (!tf) begin
                m_txv = 1; m_tx = 0;
            end
        end else if (m_read) begin
            m_wait++;
            if (dv) begin
                m_txd = dd; m_read = 0; m_tx = 1;
            end else if (m_wait == T) begin
                m_err = 1; m_read = 0;
            end
        end else if (rv) begin
            q.push_back(rb);
            if (q[0] != 8'hAA && q[0] != 8'hBB) begin
                m_err = 1; q.delete();
            end else if (q.size() == 2) begin
                a = q[1];
                if (a > 8'd15) begin
                    m_err = 1; q.delete();
                end else begin
                    m_addr = a[3:0];
                    if (q[0] == 8'hBB) begin
                        m_read = 1; m_wait = 0; m_rd = 1; q.delete();
                    end
                end
            end else if (q.size() == 3) begin
                m_wd = q[2]; m_wr = 1; q.delete();
            end
        end
    endtask

    vec_t vt[$];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.rx_d_vld = 1'b0; bus.rx_p_data = 8'h00;
        bus.rd_data_vld = 1'b0; bus.rd_data = 8'h00; bus.tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", outv(), 25'd0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        vt.push_back('{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h0,8'h00,8'h00)});
        vt.push_back('{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h5,8'h00,8'h00)});
        vt.push_back('{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, ov(1,0,0,0,0,4'h5,8'h3C,8'h00)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,0,4'h5,8'h3C,8'h00)});
        vt.push_back('{1'b1, 8'hBB, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h5,8'h3C,8'h00)});
        vt.push_back('{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, ov(0,1,0,0,1,4'h2,8'h3C,8'h00)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h2,8'h3C,8'h00)});
        vt.push_back('{1'b0, 8'h00, 1'b1, 8'h81, 1'b0, ov(0,0,0,0,1,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,1,0,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, ov(0,0,0,1,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'h1F, 1'b0, 8'h00, 1'b0, ov(0,0,0,1,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, ov(0,0,0,1,0,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'h2,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'hF,8'h3C,8'h81)});
        vt.push_back('{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, ov(1,0,0,0,0,4'hF,8'hA5,8'h81)});
        vt.push_back('{1'b1, 8'hBB, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,1,4'hF,8'hA5,8'h81)});
        vt.push_back('{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, ov(0,0,0,1,0,4'hF,8'hA5,8'h81)});
        vt.push_back('{1'b0, 8'hAA, 1'b0, 8'h00, 1'b0, ov(0,0,0,0,0,4'hF,8'hA5,8'h81)});
        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rx_v, vt[i].rx_b, vt[i].rd_v, vt[i].rd_d, vt[i].tx_f);
            chk($sformatf("vec%0d", i), outv(), vt[i].exp);
        end

        // ---------------- backpressure, bytes dropped in TX_SEND ----------------
        cyc(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0); chk("bp_cmd",  outv(), ov(0,0,0,0,1,4'hF,8'hA5,8'h81));
        cyc(1'b1, 8'h07, 1'b0, 8'h00, 1'b0); chk("bp_rden", outv(), ov(0,1,0,0,1,4'h7,8'hA5,8'h81));
        cyc(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1); chk("bp_data", outv(), ov(0,0,0,0,1,4'h7,8'hA5,8'h5A));
        for (int i = 0; i < 10; i++) begin
            cyc(i[0], (i[1] ? 8'h55 : 8'hAA), 1'b0, 8'h00, 1'b1);
            chk($sformatf("bp_hold%0d", i), outv(), ov(0,0,0,0,1,4'h7,8'hA5,8'h5A));
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("bp_push", outv(), ov(0,0,1,0,0,4'h7,8'hA5,8'h5A));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("bp_once", outv(), ov(0,0,0,0,0,4'h7,8'hA5,8'h5A));
        cyc(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0); chk("bp_nxt0", outv(), ov(0,0,0,0,1,4'h7,8'hA5,8'h5A));
        cyc(1'b1, 8'h09, 1'b0, 8'h00, 1'b0); chk("bp_nxt1", outv(), ov(0,0,0,0,1,4'h9,8'hA5,8'h5A));
        cyc(1'b1, 8'hE7, 1'b0, 8'h00, 1'b0); chk("bp_nxt2", outv(), ov(1,0,0,0,0,4'h9,8'hE7,8'h5A));

        // ---------------- read timeout, bytes dropped in RD_WAIT ----------------
        cyc(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0); chk("to_cmd",  outv(), ov(0,0,0,0,1,4'h9,8'hE7,8'h5A));
        cyc(1'b1, 8'h03, 1'b0, 8'h00, 1'b0); chk("to_rden", outv(), ov(0,1,0,0,1,4'h3,8'hE7,8'h5A));
        for (int i = 1; i < T; i++) begin
            cyc(1'b1, (i[0] ? 8'h55 : 8'hAA), 1'b0, 8'h00, 1'b0);
            chk($sformatf("to_wait%0d", i), outv(), ov(0,0,0,0,1,4'h3,8'hE7,8'h5A));
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("to_err",  outv(), ov(0,0,0,1,0,4'h3,8'hE7,8'h5A));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("to_idle", outv(), ov(0,0,0,0,0,4'h3,8'hE7,8'h5A));

        // ---------------- valid on the timeout edge wins ----------------
        cyc(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0); chk("vt_cmd",  outv(), ov(0,0,0,0,1,4'h3,8'hE7,8'h5A));
        cyc(1'b1, 8'h04, 1'b0, 8'h00, 1'b0); chk("vt_rden", outv(), ov(0,1,0,0,1,4'h4,8'hE7,8'h5A));
        for (int i = 1; i < T; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            chk($sformatf("vt_wait%0d", i), outv(), ov(0,0,0,0,1,4'h4,8'hE7,8'h5A));
        end
        cyc(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0); chk("vt_data", outv(), ov(0,0,0,0,1,4'h4,8'hE7,8'hC3));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("vt_push", outv(), ov(0,0,1,0,0,4'h4,8'hE7,8'hC3));

        // ---------------- reset mid-command ----------------
        cyc(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0); chk("rs_cmd",  outv(), ov(0,0,0,0,1,4'h4,8'hE7,8'hC3));
        cyc(1'b1, 8'h05, 1'b0, 8'h00, 1'b0); chk("rs_addr", outv(), ov(0,0,0,0,1,4'h5,8'hE7,8'hC3));
        rst = 1'b1;
        #1;
        chk("rs_async", outv(), 25'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0); chk("rs_nowr", outv(), ov(0,0,0,1,0,4'h0,8'h00,8'h00));
        cyc(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0); chk("rs_rd0",  outv(), ov(0,0,0,0,1,4'h0,8'h00,8'h00));
        cyc(1'b1, 8'h05, 1'b0, 8'h00, 1'b0); chk("rs_rd1",  outv(), ov(0,1,0,0,1,4'h5,8'h00,8'h00));
        cyc(1'b0, 8'h00, 1'b1, 8'h99, 1'b0); chk("rs_rd2",  outv(), ov(0,0,0,0,1,4'h5,8'h00,8'h99));
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); chk("rs_rd3",  outv(), ov(0,0,1,0,0,4'h5,8'h00,8'h99));

        // ---------------- randomized traffic vs. model ----------------
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        begin
            int         rd_cd;
            int         r;
            logic       rv, dv, tf;
            logic [7:0] rb, dd;
            rd_cd = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 399) == 0) begin
                    rst = 1'b1;
                    #1;
                    chk("rand_rst", outv(), 25'd0);
                    model_reset();
                    rd_cd = 0;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                end
                rv = ($urandom_range(0, 1) == 1);
                r  = $urandom_range(0, 9);
                if (r < 3)      rb = 8'hAA;
                else if (r < 6) rb = 8'hBB;
                else if (r < 9) rb = 8'($urandom_range(0, 15));
                else            rb = 8'($urandom_range(0, 255));
                dv = 1'b0;
                if (rd_cd != 0) begin
                    if (rd_cd == 1) dv = 1'b1;
                    rd_cd--;
                end else if ($urandom_range(0, 29) == 0) begin
                    dv = 1'b1;
                end
                dd = 8'($urandom_range(0, 255));
                tf = ($urandom_range(0, 2) == 0);
                model_step(rv, rb, dv, dd, tf);
                cyc(rv, rb, dv, dd, tf);
                chk($sformatf("rand%0d", n), outv(), mexp());
                if (m_rd) rd_cd = $urandom_range(1, T + 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
